// File: rtl/onchip_arb_pkg.sv
// Shared types and defaults for the two-requester on-chip RAM arbiter.
package onchip_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam int ARB_ADDR_W = 15;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = 4;
    localparam int HOLD_CNT_W = 4;

    // Grant streak counter step, saturating at the hold limit.
    function automatic logic [HOLD_CNT_W-1:0] hold_inc(input logic [HOLD_CNT_W-1:0] cnt,
                                                       input logic [HOLD_CNT_W-1:0] lim);
        return (cnt >= lim) ? lim : cnt + HOLD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/onchip_arb_perf_cnt.sv
// 32-bit saturating event counter with synchronous clear; clear beats increment.
module onchip_arb_perf_cnt (
    input  logic        clk,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 32'd1;
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter with bounded hold sharing one single-port RAM between r0 and r1.
// Define ONCHIP_ARB_PERF_CNT_EN to add the grant/contention performance counters.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int BE_W     = ARB_BE_W,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
`ifdef ONCHIP_ARB_PERF_CNT_EN
    input  logic              perf_clr,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_contend,
`endif
    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [BE_W-1:0]   r0_be,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [BE_W-1:0]   r1_be,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(HOLD_MAX);

    arb_state_t            state, state_nxt;
    logic [HOLD_CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic                  last_owner, last_owner_nxt;
    logic                  gnt0, gnt1;
    logic                  rd_acc, rd_pend, rd_tag;

    always_comb begin
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        last_owner_nxt = last_owner;
        // freeze parks the FSM exactly where it is
        if (!freeze && !reset) begin
            case (state)
                OWN0: begin
                    if (r0_valid && !(r1_valid && hold_cnt == HOLD_LIM)) gnt0 = 1'b1;
                    else if (r1_valid)                                   gnt1 = 1'b1;
                end
                OWN1: begin
                    if (r1_valid && !(r0_valid && hold_cnt == HOLD_LIM)) gnt1 = 1'b1;
                    else if (r0_valid)                                   gnt0 = 1'b1;
                end
                default: begin
                    if (r0_valid && r1_valid) begin
                        gnt0 = last_owner;
                        gnt1 = !last_owner;
                    end else begin
                        gnt0 = r0_valid;
                        gnt1 = r1_valid;
                    end
                end
            endcase

            if (gnt0) begin
                state_nxt      = OWN0;
                hold_cnt_nxt   = (state == OWN0) ? hold_inc(hold_cnt, HOLD_LIM) : HOLD_CNT_W'(1);
                last_owner_nxt = 1'b0;
            end else if (gnt1) begin
                state_nxt      = OWN1;
                hold_cnt_nxt   = (state == OWN1) ? hold_inc(hold_cnt, HOLD_LIM) : HOLD_CNT_W'(1);
                last_owner_nxt = 1'b1;
            end else begin
                state_nxt      = IDLE;
                hold_cnt_nxt   = '0;
            end
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;
    assign rd_acc   = (gnt0 && !r0_write) || (gnt1 && !r1_write);

    // Ungranted cycles leave the r0 fields on the bus; only chipselect/write matter then.
    always_comb begin
        mem_chipselect = gnt0 | gnt1;
        mem_write      = gnt1 ? r1_write : (gnt0 & r0_write);
        mem_address    = gnt1 ? r1_addr  : r0_addr;
        mem_byteenable = gnt1 ? r1_be    : r0_be;
        mem_writedata  = gnt1 ? r1_wdata : r0_wdata;
    end
    assign mem_clken = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
            rd_pend    <= 1'b0;
            rd_tag     <= 1'b0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            last_owner <= last_owner_nxt;
            rd_pend    <= rd_acc;
            if (rd_acc)
                rd_tag <= gnt1;
            // RAM data is valid the cycle after issue; steer it by the captured tag
            r0_rvalid  <= rd_pend && !rd_tag;
            r1_rvalid  <= rd_pend && rd_tag;
            if (rd_pend && !rd_tag) r0_rdata <= mem_readdata;
            if (rd_pend && rd_tag)  r1_rdata <= mem_readdata;
        end
    end

`ifdef ONCHIP_ARB_PERF_CNT_EN
    logic perf_rst;
    assign perf_rst = reset | perf_clr;

    onchip_arb_perf_cnt u_cnt_grant0 (
        .clk (clk), .clr (perf_rst), .inc (gnt0), .cnt (perf_grant0)
    );
    onchip_arb_perf_cnt u_cnt_grant1 (
        .clk (clk), .clr (perf_rst), .inc (gnt1), .cnt (perf_grant1)
    );
    onchip_arb_perf_cnt u_cnt_contend (
        .clk (clk), .clr (perf_rst), .inc (r0_valid && r1_valid && !freeze), .cnt (perf_contend)
    );
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed table, corner sequences and random traffic vs a reference model.
module tb_onchip_mem_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int HM = 4;

    logic clk = 1'b0;
    logic reset, freeze;
    logic r0_valid, r0_write, r0_ready, r0_rvalid;
    logic r1_valid, r1_write, r1_ready, r1_rvalid;
    logic [AW-1:0] r0_addr, r1_addr, mem_address;
    logic [BW-1:0] r0_be, r1_be, mem_byteenable;
    logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_writedata, mem_readdata;
    logic mem_chipselect, mem_write, mem_clken;
`ifdef ONCHIP_ARB_PERF_CNT_EN
    logic perf_clr;
    logic [31:0] perf_grant0, perf_grant1, perf_contend;
`endif

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .HOLD_MAX(HM)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
`ifdef ONCHIP_ARB_PERF_CNT_EN
        .perf_clr(perf_clr), .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_contend(perf_contend),
`endif
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_be(r0_be),
        .r0_wdata(r0_wdata), .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_be(r1_be),
        .r1_wdata(r1_wdata), .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // RAM environment driven only by the DUT's memory port
    logic [DW-1:0] ram    [0:32767];
    logic [DW-1:0] shadow [0:32767];

    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            for (int b = 0; b < BW; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        if (mem_chipselect && !mem_write)
            mem_readdata <= ram[mem_address];
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hC3C3_0000 ^ 32'(i) ^ (32'(i) << 17);
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM, how long, who won last, and reads in flight.
    typedef struct { bit v; bit tag; logic [31:0] d; } rsp_t;
    int          m_owner, m_streak;
    bit          m_last;
    rsp_t        s1, s2;
    logic [31:0] m_rdata [2];

    task automatic model_reset();
        m_owner = -1; m_streak = 0; m_last = 1'b1;
        s1.v = 1'b0; s2.v = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    function automatic int pick();
        if (reset || freeze || (!r0_valid && !r1_valid)) return -1;
        if (!r1_valid) return 0;
        if (!r0_valid) return 1;
        if (m_owner < 0) return m_last ? 0 : 1;
        if (m_streak >= HM) return 1 - m_owner;
        return m_owner;
    endfunction

    // Check one cycle at the falling edge, advance the model, then move past the next rising edge.
    task automatic cycle(output bit rd0, output bit rd1);
        int g;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
        bit we;
        @(negedge clk);
        rd0 = r0_ready; rd1 = r1_ready;
        g = pick();
        chk("r0_ready", r0_ready, g == 0);
        chk("r1_ready", r1_ready, g == 1);
        chk("r0_rvalid", r0_rvalid, s2.v && !s2.tag);
        chk("r1_rvalid", r1_rvalid, s2.v && s2.tag);
        chk("r0_rdata", r0_rdata, m_rdata[0]);
        chk("r1_rdata", r1_rdata, m_rdata[1]);
        if (g >= 0) begin
            a  = (g == 1) ? r1_addr  : r0_addr;
            we = (g == 1) ? r1_write : r0_write;
            be = (g == 1) ? r1_be    : r0_be;
            wd = (g == 1) ? r1_wdata : r0_wdata;
            chk("mem_cmd", {mem_chipselect, mem_write, mem_address}, {1'b1, we, a});
            if (we) chk("mem_wr", {mem_byteenable, mem_writedata}, {be, wd});
        end else begin
            chk("mem_idle", {mem_chipselect, mem_write}, 2'b00);
        end
        if (reset) begin
            model_reset();
        end else begin
            if (s1.v) m_rdata[s1.tag] = s1.d;
            s2 = s1;
            s1.v = 1'b0;
            if (g >= 0) begin
                if (we) begin
                    for (int b = 0; b < BW; b++)
                        if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    s1.v = 1'b1; s1.tag = (g == 1); s1.d = shadow[a];
                end
                m_streak = (g == m_owner) ? ((m_streak < HM) ? m_streak + 1 : HM) : 1;
                m_owner  = g;
                m_last   = (g == 1);
            end else if (!freeze) begin
                m_owner = -1; m_streak = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit a, b;
        cycle(a, b);
    endtask

    task automatic idle_in();
        r0_valid = 0; r0_write = 0; r0_addr = '0; r0_be = '1; r0_wdata = '0;
        r1_valid = 0; r1_write = 0; r1_addr = '0; r1_be = '1; r1_wdata = '0;
    endtask

    typedef struct { bit v0, w0, v1, w1, frz; logic [AW-1:0] a0, a1; bit e0, e1; } vec_t;
    vec_t tbl [18];

    initial begin
        bit rd0, rd1, seen;
        logic [31:0] w;

        for (int i = 0; i < 32768; i++) begin
            ram[i] = init_word(i);
            shadow[i] = ram[i];
        end
        ram[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
        idle_in();
        freeze = 0; reset = 1;
`ifdef ONCHIP_ARB_PERF_CNT_EN
        perf_clr = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state, with both requesters asking: nothing may be granted
        r0_valid = 1; r1_valid = 1;
        tick();
        chk("mem_clken", mem_clken, 1'b1);
        reset = 0;
        idle_in();

        // table: tie-break, bounded hold, release to IDLE, strict alternation, freeze
        for (int i = 0; i < 12; i++)
            tbl[i] = '{1, 0, 1, 0, 0, AW'(i), AW'(100 + i), (i < 4 || i >= 8), (i >= 4 && i < 8)};
        tbl[12] = '{0, 0, 1, 0, 0, 15'h0,  15'd200, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 15'h0,  15'h0,   0, 0};
        tbl[14] = '{1, 1, 1, 0, 0, 15'h20, 15'h20,  1, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 15'h0,  15'h0,   0, 0};
        tbl[16] = '{1, 0, 1, 0, 0, 15'h20, 15'h21,  0, 1};
        tbl[17] = '{1, 0, 1, 0, 1, 15'h20, 15'h21,  0, 0};
        for (int i = 0; i < 18; i++) begin
            r0_valid = tbl[i].v0; r0_write = tbl[i].w0; r0_addr = tbl[i].a0;
            r1_valid = tbl[i].v1; r1_write = tbl[i].w1; r1_addr = tbl[i].a1;
            r0_wdata = 32'hA000_0000 | 32'(i); r1_wdata = 32'hB000_0000 | 32'(i);
            freeze = tbl[i].frz;
            cycle(rd0, rd1);
            chk($sformatf("tbl%0d_grant", i), {rd0, rd1}, {tbl[i].e0, tbl[i].e1});
        end
        freeze = 0; idle_in();

        // single read from r0
        r0_valid = 1; r0_addr = 15'h0010;
        tick(); idle_in(); tick();
        chk("t1_r0_rvalid", r0_rvalid, 1'b1);
        chk("t1_r0_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1_r1_rvalid", r1_rvalid, 1'b0);

        // partial write then read, then a write right behind a read of the same word
        r1_valid = 1; r1_write = 1; r1_addr = 15'h7FFF; r1_wdata = 32'h12345678; r1_be = 4'b0011;
        tick(); idle_in();
        r0_valid = 1; r0_addr = 15'h7FFF;
        tick(); idle_in();
        r1_valid = 1; r1_write = 1; r1_addr = 15'h7FFF; r1_wdata = 32'h0; r1_be = 4'hF;
        tick(); idle_in();
        w = init_word(32'h7FFF);
        chk("t3_r0_rdata", r0_rdata, {w[31:16], 16'h5678});

        // freeze right after an accepted read
        r0_valid = 1; r0_addr = 15'h0010;
        tick();
        freeze = 1; r1_valid = 1; seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= r0_rvalid;
        end
        chk("t4_rvalid_in_freeze", seen, 1'b1);
        freeze = 0;
        cycle(rd0, rd1);
        chk("t4_resume", rd0 | rd1, 1'b1);
        idle_in(); tick(); tick();

        // reset the cycle after a read is accepted
        r0_valid = 1; r0_addr = 15'h0010;
        tick();
        reset = 1; r1_valid = 1;
        tick();
        reset = 0; seen = r0_rvalid | r1_rvalid;
        r0_write = 1; r1_write = 1; r0_addr = 15'h30; r1_addr = 15'h31;
        cycle(rd0, rd1);
        chk("t5_first_grant", {rd0, rd1}, 2'b10);
        idle_in();
        for (int i = 0; i < 3; i++) begin
            seen |= r0_rvalid | r1_rvalid;
            tick();
        end
        chk("t5_no_rvalid", seen, 1'b0);

`ifdef ONCHIP_ARB_PERF_CNT_EN
        perf_clr = 1; tick(); perf_clr = 0;
        r0_valid = 1; r1_valid = 1; r0_addr = 15'h40; r1_addr = 15'h41;
        repeat (10) tick();
        r1_valid = 0;
        repeat (3) tick();
        idle_in(); tick();
        chk("t6_contend", perf_contend, 32'd10);
        chk("t6_grants", perf_grant0 + perf_grant1, 32'd13);
        r0_valid = 1; r1_valid = 1; perf_clr = 1;
        tick();
        perf_clr = 0; idle_in();
        chk("t6_clr", {perf_grant0, perf_grant1}, 64'd0);
        chk("t6_clr_contend", perf_contend, 32'd0);
        tick();
`endif

        // random traffic on a small shared window
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            freeze   = ($urandom_range(0, 9) == 0);
            r0_valid = ($urandom_range(0, 3) != 0);
            r0_write = ($urandom_range(0, 2) == 0);
            r0_addr  = 15'h7FF8 + AW'($urandom_range(0, 7));
            r0_be    = BW'($urandom);
            r0_wdata = $urandom;
            r1_valid = ($urandom_range(0, 3) != 0);
            r1_write = ($urandom_range(0, 2) == 0);
            r1_addr  = 15'h7FF8 + AW'($urandom_range(0, 7));
            r1_be    = BW'($urandom);
            r1_wdata = $urandom;
            tick();
        end
        reset = 0; freeze = 0; idle_in();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
